fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall_i  input  1  decode stage not accepting; if_* outputs held.
REQ-005 SHALL have port br_taken_i  input  1  redirect request from execute stage.
REQ-006 SHALL have port br_target_i  input  32  redirect PC.
REQ-007 SHALL have port imem_req_o  output  1  single-cycle instruction-memory request strobe.
REQ-008 SHALL have port imem_addr_o  output  32  request address, valid while imem_req_o=1.
REQ-009 SHALL have port imem_rvalid_i  input  1  response strobe, at least 1 cycle after request.
REQ-010 SHALL have port imem_rdata_i  input  32  instruction word, valid with imem_rvalid_i.
REQ-011 SHALL have port if_valid_o  output  1  IF/ID register holds a live instruction.
REQ-012 SHALL have port if_pc_o  output  32  PC of the if_inst_o instruction.
REQ-013 SHALL have port if_inst_o  output  32  instruction to decode stage.

Function
REQ-014 SHALL keep at most one imem request outstanding; imem_req_o high for exactly one cycle per request.
REQ-015 SHALL implement FSM states IDLE (none outstanding), WAIT (request outstanding), KILL (outstanding response to be discarded).
REQ-016 IDLE SHALL issue imem_req_o=1, imem_addr_o=pc, and go to WAIT when the skid buffer is empty and br_taken_i=0; otherwise stay IDLE, no request.
REQ-017 WAIT SHALL, on imem_rvalid_i=1 with br_taken_i=0, deliver {pc, imem_rdata_i}, set pc=pc+4 (mod 2^32), and go to IDLE.
REQ-018 Delivery SHALL load the IF/ID register if it is empty or consumed this cycle (stall_i=0); otherwise load the one-entry skid buffer.
REQ-019 The IF/ID register SHALL be consumed when if_valid_o=1 and stall_i=0; next content SHALL be the skid entry if full, else the arriving response, else if_valid_o=0.
REQ-020 While stall_i=1 and no redirect, if_valid_o, if_pc_o, if_inst_o SHALL stay unchanged.
REQ-021 br_taken_i=1 SHALL have priority over stall_i and responses: clear if_valid_o and the skid buffer, set if_inst_o=32'h0000_0013, set pc={br_target_i[31:2],2'b00}.
REQ-022 Redirect in WAIT with imem_rvalid_i=0 SHALL go to KILL; with imem_rvalid_i=1 the response SHALL be dropped and the FSM SHALL go to IDLE.
REQ-023 KILL SHALL discard the next imem_rvalid_i response, then go to IDLE; another redirect in KILL SHALL update pc and stay in KILL.
REQ-024 Redirect in IDLE SHALL issue no request that cycle; fetch from the target begins the following cycle.
REQ-025 imem_rvalid_i in IDLE SHALL be ignored.
REQ-026 Minimum latency: redirect at cycle N -> request to target at N+1 from IDLE; response at cycle M -> if_valid_o=1 at M+1 when the slot is free.

Reset
REQ-027 reset=1 SHALL set pc=RESET_PC, FSM=IDLE, skid empty, imem_req_o=0, imem_addr_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=32'h0000_0013.
REQ-028 reset SHALL override all other inputs, including mid-WAIT; a response arriving after reset release in IDLE SHALL be discarded.
REQ-029 First request SHALL issue in the first cycle with reset=0, at address RESET_PC.

Verification
REQ-030 Memory with 1-cycle latency, stall_i=0 after reset -> requests at 0x0, 0x4, 0x8; if_pc_o follows with if_inst_o equal to the memory word.
REQ-031 stall_i=1 for 4 cycles while holding PC 0x4 -> outputs frozen; next word in skid; no new request; after release, 0x8 then 0xC delivered in order.
REQ-032 br_taken_i=1, target 0x100, in WAIT with 3-cycle memory -> stale response dropped; next if_pc_o=0x100 with valid; no instruction from the old stream.
REQ-033 Redirect to 0x203 concurrent with stall_i=1 and rvalid -> if_valid_o=0 next cycle; next request address 0x200.
REQ-034 reset asserted while WAIT -> all outputs at reset values next cycle; a late rvalid is ignored; first request at RESET_PC.
REQ-035 PC wrap: redirect to 0xFFFF_FFFC, fetch two -> if_pc_o 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage. Keeps at most one instruction-memory
//            request in flight, presents fetched words to decode through an
//            IF/ID register backed by a one-entry skid buffer, and squashes
//            in-flight or buffered work on a branch redirect.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            stall_i              - decode not accepting; IF/ID held
//            br_taken_i/target_i  - redirect request and target PC
//            imem_req_o/addr_o    - one-cycle request strobe and address
//            imem_rvalid_i/rdata_i- response strobe and instruction word
//            if_valid_o/pc_o/inst_o - IF/ID register contents
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  localparam logic [1:0]  ST_IDLE = 2'd0;  // nothing outstanding
  localparam logic [1:0]  ST_WAIT = 2'd1;  // request outstanding, response wanted
  localparam logic [1:0]  ST_KILL = 2'd2;  // request outstanding, response discarded
  localparam logic [31:0] C_NOP   = 32'h0000_0013;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_skid_valid;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_inst;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;

  logic        w_issue;
  logic        w_deliver;
  logic        w_slot_free;
  logic [31:0] w_br_pc;
  logic        w_unused_tgt;

  // Redirect targets are forced word aligned; the low bits are never used.
  assign w_br_pc      = {br_target_i[31:2], 2'b00};
  assign w_unused_tgt = ^br_target_i[1:0];

  // A new request goes out only from IDLE with room guaranteed for its
  // response (skid empty), and never in a redirect cycle so that the
  // request always carries the post-redirect PC.
  assign w_issue     = !reset && (r_state == ST_IDLE) && !r_skid_valid && !br_taken_i;
  assign w_deliver   = (r_state == ST_WAIT) && imem_rvalid_i && !br_taken_i;
  assign w_slot_free = !r_if_valid || !stall_i;

  assign imem_req_o  = w_issue;
  assign imem_addr_o = w_issue ? r_pc : 32'h0000_0000;
  assign if_valid_o  = r_if_valid;
  assign if_pc_o     = r_if_pc;
  assign if_inst_o   = r_if_inst;

  // Request FSM and fetch PC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (br_taken_i) begin
            r_pc <= w_br_pc;
          end else if (w_issue) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (br_taken_i) begin
            r_pc <= w_br_pc;
            // A response landing with the redirect is simply dropped;
            // otherwise it is still on its way and must be swallowed later.
            r_state <= imem_rvalid_i ? ST_IDLE : ST_KILL;
          end else if (imem_rvalid_i) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= ST_IDLE;
          end
        end
        ST_KILL: begin
          if (br_taken_i) begin
            r_pc <= w_br_pc;
          end
          // The stale response closes the transaction even if a further
          // redirect arrives in the same cycle.
          if (imem_rvalid_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // IF/ID register and skid buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_valid   <= 1'b0;
      r_if_pc      <= 32'h0000_0000;
      r_if_inst    <= C_NOP;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= 32'h0000_0000;
      r_skid_inst  <= 32'h0000_0000;
    end else if (br_taken_i) begin
      r_if_valid   <= 1'b0;
      r_if_inst    <= C_NOP;
      r_skid_valid <= 1'b0;
    end else if (w_slot_free) begin
      // Skid is older than anything arriving now; a delivery cannot coincide
      // with a full skid because no request is issued while it is full.
      if (r_skid_valid) begin
        r_if_valid   <= 1'b1;
        r_if_pc      <= r_skid_pc;
        r_if_inst    <= r_skid_inst;
        r_skid_valid <= 1'b0;
      end else if (w_deliver) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_pc;
        r_if_inst  <= imem_rdata_i;
      end else begin
        r_if_valid <= 1'b0;
      end
    end else if (w_deliver) begin
      r_skid_valid <= 1'b1;
      r_skid_pc    <= r_pc;
      r_skid_inst  <= imem_rdata_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A queue-based model of the
//            fetch pipeline predicts every output each cycle; a small memory
//            model answers requests with programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .if_valid_o   (if_valid_o),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int lat      = 1;

  // memory model: one pending response
  logic        p_valid = 1'b0;
  int          p_due   = 0;
  logic [31:0] p_addr  = 32'h0;

  // pipeline model: fetch PC, outstanding request, pending discard,
  // and an ordered queue of {pc, inst} waiting for decode (front = IF/ID)
  logic        m_init = 1'b0;
  logic [31:0] m_pc   = 32'h0;
  logic        m_out  = 1'b0;
  logic        m_kill = 1'b0;
  logic [63:0] mq[$];
  logic        m_blank     = 1'b0;
  logic        m_blank_rst = 1'b0;

  // snapshots of the latest sampled outputs
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %08h expected %08h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic br, input logic [31:0] tgt,
                      input logic stl, input logic inj);
    logic        rv;
    logic [31:0] rd;
    logic        exp_req;
    @(negedge clk);
    rv = 1'b0;
    rd = 32'h0;
    if (p_valid && cyc == p_due) begin
      rv = 1'b1;
      rd = memw(p_addr);
    end else if (inj && (rst || !m_out)) begin
      rv = 1'b1;
      rd = $urandom;
    end
    reset = rst; br_taken_i = br; br_target_i = tgt; stall_i = stl;
    imem_rvalid_i = rv; imem_rdata_i = rd;
    #1;
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = if_valid_o;
    s_pc = if_pc_o; s_inst = if_inst_o;
    exp_req = !rst && !br && !m_out && (mq.size() <= 1);
    if (m_init) begin
      chk("imem_req", {31'b0, s_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", s_addr, m_pc);
      chk("if_valid", {31'b0, s_valid}, {31'b0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("if_pc", s_pc, mq[0][63:32]);
        chk("if_inst", s_inst, mq[0][31:0]);
      end
      if (m_blank) chk("if_inst_nop", s_inst, 32'h0000_0013);
      if (m_blank_rst) chk("if_pc_reset", s_pc, 32'h0);
    end
    @(posedge clk);
    // memory
    if (rst) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && cyc == p_due) p_valid = 1'b0;
      if (s_req) begin
        p_valid = 1'b1;
        p_due   = cyc + lat;
        p_addr  = s_addr;
      end
    end
    // pipeline model
    if (rst) begin
      m_init = 1'b1; m_pc = RESET_PC; m_out = 1'b0; m_kill = 1'b0;
      mq.delete(); m_blank = 1'b1; m_blank_rst = 1'b1;
    end else if (br) begin
      mq.delete(); m_pc = {tgt[31:2], 2'b00}; m_blank = 1'b1; m_blank_rst = 1'b0;
      if (m_out && rv) begin
        m_out = 1'b0; m_kill = 1'b0;
      end else if (m_out) begin
        m_kill = 1'b1;
      end
    end else begin
      if (mq.size() > 0 && !stl) void'(mq.pop_front());
      if (m_out && rv) begin
        if (!m_kill) begin
          mq.push_back({m_pc, rd});
          m_pc = m_pc + 32'd4;
          m_blank = 1'b0; m_blank_rst = 1'b0;
        end
        m_out = 1'b0; m_kill = 1'b0;
      end else if (exp_req) begin
        m_out = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input logic stl);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, stl, 1'b0);
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = 32'h0;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;

    // reset values and sequential fetch with 1-cycle memory
    lat = 1;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_req", {31'b0, s_req}, 32'd0);
    chk("rst_addr", s_addr, 32'h0);
    chk("rst_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_pc", s_pc, 32'h0);
    chk("rst_inst", s_inst, 32'h0000_0013);
    run(1, 1'b0);                                   // c0
    chk("first_req", {31'b0, s_req}, 32'd1);
    chk("first_addr", s_addr, RESET_PC);
    run(2, 1'b0);                                   // c1, c2
    chk("c2_valid", {31'b0, s_valid}, 32'd1);
    chk("c2_pc", s_pc, 32'h0);
    chk("c2_inst", s_inst, memw(32'h0));
    chk("c2_addr", s_addr, 32'h4);
    run(1, 1'b0);                                   // c3

    // stall for 4 cycles while holding PC 0x4
    run(1, 1'b1);                                   // c4
    chk("c4_pc", s_pc, 32'h4);
    chk("c4_addr", s_addr, 32'h8);
    run(2, 1'b1);                                   // c5, c6
    chk("stall_noreq", {31'b0, s_req}, 32'd0);
    run(1, 1'b1);                                   // c7
    chk("stall_hold_pc", s_pc, 32'h4);
    run(2, 1'b0);                                   // c8, c9
    chk("skid_pc", s_pc, 32'h8);
    run(1, 1'b0);                                   // c10
    lat = 3;
    run(1, 1'b0);                                   // c11
    chk("c11_pc", s_pc, 32'hC);
    chk("c11_inst", s_inst, memw(32'hC));

    // redirect to 0x100 while waiting on a 3-cycle memory
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);          // c12
    run(1, 1'b0);                                   // c13
    chk("br_valid", {31'b0, s_valid}, 32'd0);
    chk("br_inst", s_inst, 32'h0000_0013);
    run(2, 1'b0);                                   // c14, c15
    chk("br_req_addr", s_addr, 32'h100);
    run(4, 1'b0);                                   // c16..c19
    chk("br_tgt_valid", {31'b0, s_valid}, 32'd1);
    chk("br_tgt_pc", s_pc, 32'h100);

    // redirect to 0x203 with stall and response in the same cycle
    run(2, 1'b1);                                   // c20, c21
    step(1'b0, 1'b1, 32'h203, 1'b1, 1'b0);          // c22 (response due)
    run(1, 1'b0);                                   // c23
    chk("br2_valid", {31'b0, s_valid}, 32'd0);
    chk("br2_req", {31'b0, s_req}, 32'd1);
    chk("br2_addr", s_addr, 32'h200);

    // PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);    // c24
    run(2, 1'b0);                                   // c25, c26
    lat = 1;
    run(3, 1'b0);                                   // c27..c29
    chk("wrap_pc0", s_pc, 32'hFFFF_FFFC);
    chk("wrap_req", {31'b0, s_req}, 32'd1);
    chk("wrap_addr", s_addr, 32'h0);
    run(1, 1'b0);                                   // c30
    lat = 3;
    run(1, 1'b0);                                   // c31
    chk("wrap_pc1", s_pc, 32'h0);

    // reset while a request is outstanding, stray responses around it
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);            // c32
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);            // c33
    chk("rst2_req", {31'b0, s_req}, 32'd0);
    chk("rst2_addr", s_addr, 32'h0);
    chk("rst2_valid", {31'b0, s_valid}, 32'd0);
    chk("rst2_pc", s_pc, 32'h0);
    chk("rst2_inst", s_inst, 32'h0000_0013);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);            // c34
    chk("rst2_req1", {31'b0, s_req}, 32'd1);
    chk("rst2_addr1", s_addr, RESET_PC);
    run(4, 1'b0);                                   // c35..c38
    chk("rst2_out_valid", {31'b0, s_valid}, 32'd1);
    chk("rst2_out_pc", s_pc, RESET_PC);
    chk("rst2_out_inst", s_inst, memw(RESET_PC));

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      lat = $urandom_range(1, 4);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom,
           $urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
